lsu_misalign_splitter: RTL and testbench

- Load/store unit front end between the execute stage and data_memory.
- Aligned loads and stores pass to data_memory in a single access.
- Misaligned half/word accesses are split into sequential byte accesses; load data is reassembled and extended locally.
- Replies to the core through a valid/ready request channel and a one-cycle response pulse.

---
 rtl/riscv_pkg.sv | 27 ++
 rtl/lsu_misalign_splitter_assembler.sv | 24 ++
 rtl/lsu_misalign_splitter.sv | 157 +++++++++++++++
 tb/tb_lsu_misalign_splitter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V memory-access types and helpers for the load/store unit.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE,
    SPLIT,
    RESP
  } lsu_state_e;

  // Only the two address LSBs matter for natural alignment.
  function automatic logic is_misaligned(input logic [1:0] addr, input logic [1:0] size);
    case (size)
      MEM_HALF: return addr[0];
      MEM_WORD: return (addr != 2'b00);
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_misalign_splitter_assembler.sv
// Byte-lane insert into the split-load assembly word plus final zero/sign extension.
module lsu_byte_assembler
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] asm_i,
  input  logic [1:0]      lane_i,
  input  logic [7:0]      byte_i,
  input  logic [1:0]      size_i,
  input  logic            sign_ext_i,
  output logic [XLEN-1:0] asm_o,
  output logic [XLEN-1:0] ext_o
);

  always_comb begin
    asm_o = asm_i;
    asm_o[{lane_i, 3'b000} +: 8] = byte_i;
    case (size_i)
      MEM_HALF: ext_o = {{(XLEN-16){sign_ext_i & asm_o[15]}}, asm_o[15:0]};
      MEM_WORD: ext_o = asm_o;
      default:  ext_o = {{(XLEN-8){sign_ext_i & asm_o[7]}}, asm_o[7:0]};
    endcase
  end

endmodule

// File: rtl/lsu_misalign_splitter.sv
// LSU front end: aligned accesses pass straight to data_memory; misaligned
// half/word accesses become sequential byte accesses with local reassembly.
module lsu_misalign_splitter
  import riscv_pkg::*;
#(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_write_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  input  logic [1:0]      req_size_i,
  input  logic            req_sign_ext_i,
  output logic            resp_valid_o,
  output logic [XLEN-1:0] resp_rdata_o,
  output logic            resp_err_o,
  output logic            resp_split_o,
  output logic            mem_write_en_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_write_data_o,
  output logic [1:0]      mem_size_o,
  output logic            mem_sign_ext_o,
  input  logic [XLEN-1:0] mem_read_data_i
);

  lsu_state_e      state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [1:0]      size_q, size_d;
  logic            sign_q, sign_d;
  logic            write_q, write_d;
  logic [1:0]      k_q, k_d;
  logic [XLEN-1:0] asm_q, asm_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            split_q, split_d;

  logic [XLEN-1:0] asm_ins, asm_ext;
  logic            mis, illegal;
  logic [1:0]      last_k;

  lsu_byte_assembler u_asm (
    .asm_i      (asm_q),
    .lane_i     (k_q),
    .byte_i     (mem_read_data_i[7:0]),
    .size_i     (size_q),
    .sign_ext_i (sign_q),
    .asm_o      (asm_ins),
    .ext_o      (asm_ext)
  );

  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    size_d           = size_q;
    sign_d           = sign_q;
    write_d          = write_q;
    k_d              = k_q;
    asm_d            = asm_q;
    rdata_d          = rdata_q;
    err_d            = err_q;
    split_d          = split_q;
    req_ready_o      = 1'b0;
    mem_write_en_o   = 1'b0;
    mem_addr_o       = '0;
    mem_write_data_o = '0;
    mem_size_o       = MEM_BYTE;
    mem_sign_ext_o   = 1'b0;
    mis              = is_misaligned(req_addr_i[1:0], req_size_i);
    illegal          = (req_size_i == 2'b11);
    last_k           = (size_q == MEM_WORD) ? 2'd3 : 2'd1;

    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          rdata_d = '0;
          err_d   = 1'b0;
          split_d = 1'b0;
          state_d = RESP;
          if (illegal || (mis && !ALLOW_MISALIGNED)) begin
            err_d = 1'b1;
          end else if (mis) begin
            addr_d  = req_addr_i;
            wdata_d = req_wdata_i;
            size_d  = req_size_i;
            sign_d  = req_sign_ext_i;
            write_d = req_write_i;
            k_d     = 2'd0;
            asm_d   = '0;
            state_d = SPLIT;
          end else begin
            mem_write_en_o   = req_write_i;
            mem_addr_o       = req_addr_i;
            mem_write_data_o = req_wdata_i;
            mem_size_o       = req_size_i;
            mem_sign_ext_o   = req_sign_ext_i;
            if (!req_write_i) rdata_d = mem_read_data_i;
          end
        end
      end
      SPLIT: begin
        // Address arithmetic wraps naturally at 2^XLEN.
        mem_addr_o       = addr_q + XLEN'(k_q);
        mem_write_data_o = {{(XLEN-8){1'b0}}, wdata_q[{k_q, 3'b000} +: 8]};
        mem_write_en_o   = write_q;
        if (!write_q) asm_d = asm_ins;
        k_d = k_q + 2'd1;
        if (k_q == last_k) begin
          split_d = 1'b1;
          rdata_d = write_q ? '0 : asm_ext;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= MEM_BYTE;
      sign_q  <= 1'b0;
      write_q <= 1'b0;
      k_q     <= 2'd0;
      asm_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      split_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      write_q <= write_d;
      k_q     <= k_d;
      asm_q   <= asm_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      split_q <= split_d;
    end
  end

  assign resp_valid_o = (state_q == RESP);
  assign resp_rdata_o = resp_valid_o ? rdata_q : '0;
  assign resp_err_o   = resp_valid_o & err_q;
  assign resp_split_o = resp_valid_o & split_q;

endmodule

// File: tb/tb_lsu_misalign_splitter.sv
// Scoreboard bench: a byte-array data_memory model, expected writes and responses queued at issue.
module tb_lsu_misalign_splitter;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    logic        split;
    int          lat;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_valid1 = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  req_size = 2'b00;
  logic        req_sign = 1'b0;

  logic        req_ready, resp_valid, resp_err, resp_split;
  logic [31:0] resp_rdata;
  logic        mem_we, mem_sext;
  logic [31:0] mem_addr, mem_wd, mem_rd;
  logic [1:0]  mem_size;

  logic        req_ready1, resp_valid1, resp_err1, resp_split1;
  logic [31:0] resp_rdata1;
  logic        mem_we1, mem_sext1;
  logic [31:0] mem_addr1, mem_wd1;
  logic [1:0]  mem_size1;

  logic [7:0]  mem [0:255];
  logic [31:0] w;

  resp_t resp_q[$];
  wr_t   wr_q[$];
  int    n_cmp = 0, n_err = 0;
  int    cycle = 0, accept_cycle = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  lsu_misalign_splitter #(.ALLOW_MISALIGNED(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_size_i(req_size),
    .req_sign_ext_i(req_sign),
    .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
    .resp_split_o(resp_split),
    .mem_write_en_o(mem_we), .mem_addr_o(mem_addr), .mem_write_data_o(mem_wd),
    .mem_size_o(mem_size), .mem_sign_ext_o(mem_sext), .mem_read_data_i(mem_rd)
  );

  lsu_misalign_splitter #(.ALLOW_MISALIGNED(1'b0)) dut_strict (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid1), .req_ready_o(req_ready1), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_size_i(req_size),
    .req_sign_ext_i(req_sign),
    .resp_valid_o(resp_valid1), .resp_rdata_o(resp_rdata1), .resp_err_o(resp_err1),
    .resp_split_o(resp_split1),
    .mem_write_en_o(mem_we1), .mem_addr_o(mem_addr1), .mem_write_data_o(mem_wd1),
    .mem_size_o(mem_size1), .mem_sign_ext_o(mem_sext1), .mem_read_data_i(32'hCAFEF00D)
  );

  // data_memory model: combinational read with extension, write on the clock edge
  always_comb begin
    w = {mem[mem_addr[7:0] + 8'd3], mem[mem_addr[7:0] + 8'd2],
         mem[mem_addr[7:0] + 8'd1], mem[mem_addr[7:0]]};
    case (mem_size)
      2'b00:   mem_rd = {{24{mem_sext & w[7]}}, w[7:0]};
      2'b01:   mem_rd = {{16{mem_sext & w[15]}}, w[15:0]};
      default: mem_rd = w;
    endcase
  end

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr[7:0]] <= mem_wd[7:0];
      if (mem_size != 2'b00) mem[mem_addr[7:0] + 8'd1] <= mem_wd[15:8];
      if (mem_size == 2'b10) begin
        mem[mem_addr[7:0] + 8'd2] <= mem_wd[23:16];
        mem[mem_addr[7:0] + 8'd3] <= mem_wd[31:24];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Monitor: writes and responses checked away from the active edge.
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      if (wr_q.size() == 0) chk("wr_unexpected", mem_addr, 32'hFFFF_FFFF);
      else begin
        wr_t e;
        e = wr_q.pop_front();
        chk("wr_addr", mem_addr, e.addr);
        chk("wr_data", mem_wd, e.data);
        chk("wr_size", {30'b0, mem_size}, {30'b0, e.size});
      end
    end
    if (rst_n && resp_valid) begin
      if (resp_q.size() == 0) chk("resp_unexpected", resp_rdata, 32'hFFFF_FFFF);
      else begin
        resp_t e;
        e = resp_q.pop_front();
        chk("resp_rdata", resp_rdata, e.rd);
        chk("resp_err", {31'b0, resp_err}, {31'b0, e.err});
        chk("resp_split", {31'b0, resp_split}, {31'b0, e.split});
        chk("resp_latency", 32'(cycle - accept_cycle), 32'(e.lat));
      end
    end
  end

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    wr_q.push_back('{a, d, sz});
  endtask

  // Called at posedge+1; returns at posedge+1 after the acceptance edge.
  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] sz, input logic se,
                       input logic [31:0] exp_rd, input logic exp_err, input logic exp_split,
                       input int lat, input bit expect_resp);
    int n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) chk("ready_timeout", 32'd0, 32'd1);
    if (expect_resp) resp_q.push_back('{exp_rd, exp_err, exp_split, lat});
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    req_size = sz; req_sign = se;
    accept_cycle = cycle;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    req_size = 2'($urandom); req_sign = 1'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((resp_q.size() != 0 || wr_q.size() != 0) && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // aligned word store then load; aligned half/byte loads extended by memory
    push_wr(32'h10, 32'hDEADBEEF, 2'b10);
    issue(1, 32'h10, 32'hDEADBEEF, 2'b10, 0, 32'h0, 0, 0, 1, 1);
    issue(0, 32'h10, 32'h0, 2'b10, 0, 32'hDEADBEEF, 0, 0, 1, 1);
    issue(0, 32'h12, 32'h0, 2'b01, 1, 32'hFFFFDEAD, 0, 0, 1, 1);
    issue(0, 32'h13, 32'h0, 2'b00, 0, 32'h000000DE, 0, 0, 1, 1);

    // split word store at 0x21 and split load back
    push_wr(32'h21, 32'h44, 2'b00); push_wr(32'h22, 32'h33, 2'b00);
    push_wr(32'h23, 32'h22, 2'b00); push_wr(32'h24, 32'h11, 2'b00);
    issue(1, 32'h21, 32'h11223344, 2'b10, 0, 32'h0, 0, 1, 5, 1);
    issue(0, 32'h21, 32'h0, 2'b10, 0, 32'h11223344, 0, 1, 5, 1);

    // split half store at 0x43, signed and unsigned split loads
    push_wr(32'h43, 32'hF0, 2'b00); push_wr(32'h44, 32'h80, 2'b00);
    issue(1, 32'h43, 32'h000080F0, 2'b01, 0, 32'h0, 0, 1, 3, 1);
    issue(0, 32'h43, 32'h0, 2'b01, 1, 32'hFFFF80F0, 0, 1, 3, 1);
    issue(0, 32'h43, 32'h0, 2'b01, 0, 32'h000080F0, 0, 1, 3, 1);

    // illegal size: error, no memory access
    issue(1, 32'h0, 32'hFFFFFFFF, 2'b11, 0, 32'h0, 1, 0, 1, 1);
    issue(0, 32'h10, 32'h0, 2'b11, 1, 32'h0, 1, 0, 1, 1);
    issue(0, 32'h10, 32'h0, 2'b10, 0, 32'hDEADBEEF, 0, 0, 1, 1);

    // address wrap across 2^32
    push_wr(32'hFFFFFFFE, 32'h0D, 2'b00); push_wr(32'hFFFFFFFF, 32'h0C, 2'b00);
    push_wr(32'h00000000, 32'h0B, 2'b00); push_wr(32'h00000001, 32'h0A, 2'b00);
    issue(1, 32'hFFFFFFFE, 32'h0A0B0C0D, 2'b10, 0, 32'h0, 0, 1, 5, 1);
    issue(0, 32'hFFFFFFFE, 32'h0, 2'b10, 0, 32'h0A0B0C0D, 0, 1, 5, 1);
    drain();

    // strict instance: misaligned rejected, aligned passes through
    req_valid1 = 1'b1; req_write = 0; req_addr = 32'h2; req_size = 2'b10; req_sign = 0;
    #1;
    chk("strict_ready", {31'b0, req_ready1}, 32'd1);
    chk("strict_no_we_load", {31'b0, mem_we1}, 32'd0);
    @(posedge clk); #1;
    req_valid1 = 1'b0;
    chk("strict_err", {31'b0, resp_valid1 & resp_err1}, 32'd1);
    chk("strict_err_rdata", resp_rdata1, 32'd0);
    chk("strict_err_split", {31'b0, resp_split1}, 32'd0);
    @(posedge clk); #1;
    req_valid1 = 1'b1; req_write = 1; req_addr = 32'h1; req_wdata = 32'h1234; req_size = 2'b01;
    #1;
    chk("strict_no_we_store", {31'b0, mem_we1}, 32'd0);
    @(posedge clk); #1;
    req_valid1 = 1'b0;
    chk("strict_err_store", {31'b0, resp_valid1 & resp_err1}, 32'd1);
    @(posedge clk); #1;
    req_valid1 = 1'b1; req_write = 0; req_addr = 32'h4; req_size = 2'b10;
    @(posedge clk); #1;
    req_valid1 = 1'b0;
    chk("strict_aligned_rdata", resp_rdata1, 32'hCAFEF00D);
    chk("strict_aligned_err", {31'b0, resp_valid1 & ~resp_err1}, 32'd1);
    @(posedge clk); #1;

    // reset in the middle of a split store at 0x31
    push_wr(32'h30, 32'h00, 2'b00);
    issue(1, 32'h30, 32'h00, 2'b00, 0, 32'h0, 0, 0, 1, 1);
    push_wr(32'h33, 32'h5A, 2'b00);
    issue(1, 32'h33, 32'h5A, 2'b00, 0, 32'h0, 0, 0, 1, 1);
    push_wr(32'h34, 32'h5A, 2'b00);
    issue(1, 32'h34, 32'h5A, 2'b00, 0, 32'h0, 0, 0, 1, 1);
    push_wr(32'h31, 32'hD4, 2'b00); push_wr(32'h32, 32'hC3, 2'b00);
    issue(1, 32'h31, 32'hA1B2C3D4, 2'b10, 0, 32'h0, 0, 1, 5, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_mem_we", {31'b0, mem_we}, 32'd0);
    chk("abort_mem_addr", mem_addr, 32'd0);
    chk("abort_mem_wd", mem_wd, 32'd0);
    chk("abort_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("abort_ready", {31'b0, req_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("abort_byte31", {24'b0, mem[8'h31]}, 32'hD4);
    chk("abort_byte32", {24'b0, mem[8'h32]}, 32'hC3);
    chk("abort_byte33", {24'b0, mem[8'h33]}, 32'h5A);
    chk("abort_byte34", {24'b0, mem[8'h34]}, 32'h5A);
    chk("abort_wr_q", 32'(wr_q.size()), 32'd0);
    issue(0, 32'h30, 32'h0, 2'b10, 0, 32'h5AC3D400, 0, 0, 1, 1);
    issue(0, 32'h34, 32'h0, 2'b00, 1, 32'h0000005A, 0, 0, 1, 1);
    drain();

    chk("resp_q_left", 32'(resp_q.size()), 32'd0);
    chk("wr_q_left", 32'(wr_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
